tpu_load_sequencer: RTL
=======================

Name: tpu_load_sequencer

Overview:
- Top-level sequencer for the TPU datapath: SRAM unified buffer -> weight FIFO -> systolic array.
- On `start` it fetches NUM_PE_ROWS weight rows from SRAM into the weight FIFO, then pops each row into the array with `we_rl`.
- It then streams `n_vec` input vectors from SRAM onto DIN and waits for the array pipeline to drain.
- Sole owner of the SRAM address port and the FIFO push/pop strobes.

Parameters:
- ADDRESSSIZE, 10, SRAM address width.
- NUM_PE_ROWS, 8, weight rows to load per job.
- MATRIX_SIZE, 8, PE columns; sets the drain length.
- FIFO_DEPTH, 4, weight FIFO capacity; sets the fetch credit limit.
- VEC_CNT_BW, 8, width of `n_vec`.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- hold  in  1  pauses FIFO pops (back-pressure from the array side).
- w_base_addr  in  ADDRESSSIZE  SRAM address of weight row 0.
- d_base_addr  in  ADDRESSSIZE  SRAM address of input vector 0.
- n_vec  in  VEC_CNT_BW  number of input vectors to stream.
- fifo_empty  in  1  weight FIFO empty flag.
- fifo_full  in  1  weight FIFO full flag (checked by assertion only).
- sram_addr  out  ADDRESSSIZE  SRAM read address; SRAM read latency is 1 cycle.
- sram_write_enable  out  1  tied 0; the sequencer only reads.
- fifo_write_enable  out  1  FIFO push.
- fifo_read_enable  out  1  FIFO pop; FIFO read latency is 1 cycle.
- we_rl  out  1  array weight-load strobe.
- din_valid  out  1  SRAM data on DIN is a valid input vector.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: all outputs 0, sram_addr = 0, all counters 0, state IDLE. Reset asserted mid-job aborts the job immediately; no done pulse is produced.
- States: IDLE, W_LOAD, D_STREAM, DRAIN, FIN.
- IDLE -> W_LOAD when start = 1. Base addresses and n_vec are latched on that cycle; later changes to these inputs are ignored.
- start while busy is ignored; no queuing.
- W_LOAD fetch side:
  - Issue read `sram_addr = w_base + fetch_cnt` only when fetch_cnt < NUM_PE_ROWS and (occ + inflight) < FIFO_DEPTH.
  - inflight is the read issued last cycle, 0 or 1.
  - occ is an internal occupancy counter: +1 on push, -1 on pop, both in the same cycle leave it unchanged.
- W_LOAD push: fifo_write_enable = 1 exactly one cycle after each issued weight read.
- W_LOAD pop side:
  - fifo_read_enable = 1 when !fifo_empty, !hold and pop_cnt < NUM_PE_ROWS.
  - we_rl = 1 exactly one cycle after each pop.
- W_LOAD -> D_STREAM on the cycle after the NUM_PE_ROWS-th we_rl. If n_vec = 0, go to FIN instead.
- D_STREAM:
  - Each cycle drive `sram_addr = d_base + vec_cnt`, for n_vec consecutive cycles; hold ignored.
  - din_valid = 1 one cycle after each such address.
  - -> DRAIN on the cycle after the last address.
- DRAIN: counts NUM_PE_ROWS + MATRIX_SIZE - 1 cycles. The first DRAIN cycle coincides with the final din_valid. -> FIN at count end.
- FIN: done = 1 for one cycle, busy = 1, then -> IDLE.
- Address arithmetic is modulo 2^ADDRESSSIZE; base + i wraps silently.
- Hard invariants (assertions):
  - No push while fifo_full.
  - No pop while fifo_empty.
  - occ never exceeds FIFO_DEPTH.
  - At most one of fifo_write_enable / din_valid per address phase.
- sram_addr holds its last value when no read is issued.

Test Plan:
- Nominal job (defaults): w_base = 0x010, d_base = 0x100, n_vec = 4, hold = 0, start pulsed in cycle 0. Required response:
  - weight reads 0x010..0x017 in cycles 1-8;
  - pushes in cycles 2-9, pops in cycles 3-10, we_rl in cycles 4-11;
  - data reads 0x100..0x103 in cycles 12-15, din_valid in cycles 13-16;
  - done in cycle 32, busy high in cycles 1-32.
- Back-pressure: hold = 1 from cycle 0 to cycle 20 -> exactly 4 weight reads issued, then stall with occ = 4 and no push while fifo_full; after hold drops, the remaining 4 rows load and there are exactly 8 we_rl in total.
- n_vec = 0 -> 8 we_rl, no din_valid, no DRAIN; done on the cycle after FIN is entered.
- Wrap: w_base = 0x3FE -> weight read addresses 0x3FE, 0x3FF, 0x000..0x005.
- Reset mid-job: rst in cycle 6 -> from cycle 7 all outputs 0 and state IDLE, no done pulse; a new start then reruns the nominal timing.
- start pulsed while busy (cycle 5) -> no effect; exactly one done pulse, still in cycle 32.

Source files
------------

// File: rtl/tpu_load_sequencer.sv
// Job sequencer for the TPU datapath: loads weight rows SRAM -> weight FIFO -> array,
// then streams input vectors from SRAM onto DIN and waits for the array to drain.
module tpu_load_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int NUM_PE_ROWS = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int VEC_CNT_BW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   hold,
  input  logic [ADDRESSSIZE-1:0] w_base_addr,
  input  logic [ADDRESSSIZE-1:0] d_base_addr,
  input  logic [VEC_CNT_BW-1:0]  n_vec,
  input  logic                   fifo_empty,
  input  logic                   fifo_full,
  output logic [ADDRESSSIZE-1:0] sram_addr,
  output logic                   sram_write_enable,
  output logic                   fifo_write_enable,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic                   din_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int RW        = $clog2(NUM_PE_ROWS + 1);
  localparam int OW        = $clog2(FIFO_DEPTH + 1);
  localparam int DRAIN_LEN = NUM_PE_ROWS + MATRIX_SIZE - 1;
  localparam int DW        = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {IDLE, W_LOAD, D_STREAM, DRAIN, FIN} state_t;

  state_t                 state, state_nx;
  logic [ADDRESSSIZE-1:0] w_base_r, d_base_r, addr_r;
  logic [VEC_CNT_BW-1:0]  n_vec_r, vec_cnt;
  logic [RW-1:0]          fetch_cnt, pop_cnt, load_cnt;
  logic [OW-1:0]          occ;
  logic [DW-1:0]          drain_cnt;
  logic                   inflight, pop_d, dv_d, done_r;
  logic                   issue, pop;

  // Strobe semantics: every strobe is a single-cycle qualifier with no ready path.
  // A read issued in cycle t yields SRAM data in t+1 (push or din_valid in t+1);
  // a pop in cycle t yields FIFO data in t+1 (we_rl in t+1).
  assign sram_write_enable = 1'b0;
  assign fifo_write_enable = inflight;
  assign fifo_read_enable  = pop;
  assign we_rl             = pop_d;
  assign din_valid         = dv_d;
  assign done              = done_r;
  assign busy              = (state != IDLE) || done_r;

  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    pop       = 1'b0;
    sram_addr = addr_r;
    case (state)
      IDLE: begin
        if (start) state_nx = W_LOAD;
      end
      W_LOAD: begin
        // Credit check counts the read still in flight so the FIFO can never overflow.
        issue = (int'(fetch_cnt) < NUM_PE_ROWS) &&
                ((int'(occ) + int'(inflight)) < FIFO_DEPTH);
        pop   = !fifo_empty && !hold && (int'(pop_cnt) < NUM_PE_ROWS);
        if (issue) sram_addr = w_base_r + ADDRESSSIZE'(fetch_cnt);
        if (pop_d && (int'(load_cnt) == NUM_PE_ROWS - 1))
          state_nx = (n_vec_r == '0) ? FIN : D_STREAM;
      end
      D_STREAM: begin
        sram_addr = d_base_r + ADDRESSSIZE'(vec_cnt);
        if (vec_cnt == n_vec_r - VEC_CNT_BW'(1)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (int'(drain_cnt) == DRAIN_LEN - 1) state_nx = FIN;
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w_base_r  <= '0;
      d_base_r  <= '0;
      addr_r    <= '0;
      n_vec_r   <= '0;
      vec_cnt   <= '0;
      fetch_cnt <= '0;
      pop_cnt   <= '0;
      load_cnt  <= '0;
      occ       <= '0;
      drain_cnt <= '0;
      inflight  <= 1'b0;
      pop_d     <= 1'b0;
      dv_d      <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      addr_r   <= sram_addr;
      inflight <= issue;
      pop_d    <= pop;
      dv_d     <= (state == D_STREAM);
      done_r   <= (state == FIN);
      case ({inflight, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (issue)              fetch_cnt <= fetch_cnt + RW'(1);
      if (pop)                pop_cnt   <= pop_cnt + RW'(1);
      if (pop_d)              load_cnt  <= load_cnt + RW'(1);
      if (state == D_STREAM)  vec_cnt   <= vec_cnt + VEC_CNT_BW'(1);
      if (state == DRAIN)     drain_cnt <= drain_cnt + DW'(1);
      // Job parameters are captured once; later input changes do not disturb a running job.
      if (state == IDLE && start) begin
        w_base_r  <= w_base_addr;
        d_base_r  <= d_base_addr;
        n_vec_r   <= n_vec;
        vec_cnt   <= '0;
        fetch_cnt <= '0;
        pop_cnt   <= '0;
        load_cnt  <= '0;
        drain_cnt <= '0;
      end
    end
  end

  a_no_push_full:  assert property (@(posedge clk) disable iff (rst) !(fifo_write_enable && fifo_full));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) !(fifo_read_enable && fifo_empty));
  a_occ_bound:     assert property (@(posedge clk) disable iff (rst) int'(occ) <= FIFO_DEPTH);
  a_one_data_use:  assert property (@(posedge clk) disable iff (rst) !(fifo_write_enable && din_valid));

endmodule
